// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: the data side wins by default, and the inst side
// is forced in after MAX_CONSEC back-to-back data grants. Only one read is in flight.
module axi_rd_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction side
  input  logic        i_arvalid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [3:0]  i_arid,
  output logic        i_arready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        i_rready,
  // data side
  input  logic        d_arvalid,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic [3:0]  d_arid,
  output logic        d_arready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  input  logic        d_rready,
  // AXI master port
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [1:0]  rresp,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             grant_d_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       arid_r;
  logic [31:0]      araddr_r;
  logic [7:0]       arlen_r;
  logic [2:0]       arsize_r;

  logic             cnt_sat_s;
  logic             gnt_d_s;
  logic             gnt_i_s;
  logic             rready_s;
  logic             unused_s;

  // Single outstanding read, so the R-channel id and response are not needed.
  assign unused_s  = ^{rid, rresp};
  assign cnt_sat_s = (cnt_r >= CNT_W'(MAX_CONSEC));

  // Grant decision; the reset qualifier keeps both acks low while resetn is asserted.
  always_comb begin
    gnt_d_s = 1'b0;
    gnt_i_s = 1'b0;
    if (resetn && (state_r == ST_IDLE)) begin
      if (d_arvalid && !(i_arvalid && cnt_sat_s)) begin
        gnt_d_s = 1'b1;
      end else if (i_arvalid) begin
        gnt_i_s = 1'b1;
      end else begin
        gnt_d_s = 1'b0;
        gnt_i_s = 1'b0;
      end
    end else begin
      gnt_d_s = 1'b0;
      gnt_i_s = 1'b0;
    end
  end

  // R-channel ready follows whichever side owns the current transaction.
  always_comb begin
    rready_s = 1'b0;
    if (state_r == ST_R) begin
      rready_s = grant_d_r ? d_rready : i_rready;
    end else begin
      rready_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_d_s || gnt_i_s) begin
          state_nxt_s = ST_AR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid && rready_s && rlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_R;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture the winner's request fields at grant time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_d_r <= 1'b0;
      arid_r    <= 4'd0;
      araddr_r  <= 32'd0;
      arlen_r   <= 8'd0;
      arsize_r  <= 3'd0;
    end else if (gnt_d_s) begin
      grant_d_r <= 1'b1;
      arid_r    <= d_arid;
      araddr_r  <= d_araddr;
      arlen_r   <= d_arlen;
      arsize_r  <= d_arsize;
    end else if (gnt_i_s) begin
      grant_d_r <= 1'b0;
      arid_r    <= i_arid;
      araddr_r  <= i_araddr;
      arlen_r   <= i_arlen;
      arsize_r  <= i_arsize;
    end else begin
      grant_d_r <= grant_d_r;
      arid_r    <= arid_r;
      araddr_r  <= araddr_r;
      arlen_r   <= arlen_r;
      arsize_r  <= arsize_r;
    end
  end

  // Anti-starvation counter: counts data grants taken while the inst side waits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (gnt_d_s) begin
      if (!i_arvalid) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_sat_s) begin
        cnt_r <= cnt_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (gnt_i_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM output decode.
  always_comb begin
    i_arready = gnt_i_s;
    d_arready = gnt_d_s;
    arvalid   = (state_r == ST_AR);
    rready    = rready_s;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    if (state_r == ST_R) begin
      i_rvalid = rvalid && !grant_d_r;
      d_rvalid = rvalid && grant_d_r;
    end else begin
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

  assign arid    = arid_r;
  assign araddr  = araddr_r;
  assign arlen   = arlen_r;
  assign arsize  = arsize_r;
  assign arburst = 2'b01;
  assign i_rdata = rdata;
  assign d_rdata = rdata;
  assign i_rlast = rlast;
  assign d_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for starvation, burst, AR stall and mid-read reset.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic [3:0]  i_arid;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic [3:0]  d_arid;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter #(.MAX_CONSEC(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arid(i_arid), .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arid(d_arid), .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        d_v;
    logic [31:0] d_a;
    logic        i_v;
    logic [31:0] i_a;
    logic        ar_rdy;
    logic        rv;
    logic        rl;
    logic [31:0] rd;
    logic        i_rr;
    logic        d_rr;
    logic        e_dard;
    logic        e_iard;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rr;
    logic        e_drv;
    logic        e_irv;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_arvalid = 1'b0; i_araddr = 32'd0; i_arlen = 8'd0; i_arsize = 3'd2; i_arid = 4'd0;
    d_arvalid = 1'b0; d_araddr = 32'd0; d_arlen = 8'd0; d_arsize = 3'd2; d_arid = 4'd1;
    i_rready = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rid = 4'd0; rresp = 2'd0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
  endtask

  logic [9:0]  t3_exp;
  logic [31:0] beat_data;
  int          k;
  int          b;

  initial begin
    // d, i, both, ... columns: d_v d_a i_v i_a arready rvalid rlast rdata i_rr d_rr | expected
    tbl[0]  = '{1'b1, 32'h1c00_0040, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'h1c00_0040, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 32'h1c00_0040, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h8000_0100, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h1c00_0040, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0};

    // Reset state, with a pending data request that must not be acked.
    resetn = 1'b0;
    idle_inputs();
    d_arvalid = 1'b1;
    @(negedge clk); #1;
    chk("rst d_arready", {31'd0, d_arready}, 32'd0);
    chk("rst arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst rready", {31'd0, rready}, 32'd0);
    chk("rst araddr", araddr, 32'd0);
    chk("rst arburst", {30'd0, arburst}, 32'd1);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;

    // Table-driven: single d read, i/d collision, deferred i read.
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      d_arvalid = tbl[r].d_v;  d_araddr = tbl[r].d_a;
      i_arvalid = tbl[r].i_v;  i_araddr = tbl[r].i_a;
      arready   = tbl[r].ar_rdy;
      rvalid    = tbl[r].rv;   rlast = tbl[r].rl; rdata = tbl[r].rd;
      i_rready  = tbl[r].i_rr; d_rready = tbl[r].d_rr;
      #1;
      chk($sformatf("tbl[%0d] d_arready", r), {31'd0, d_arready}, {31'd0, tbl[r].e_dard});
      chk($sformatf("tbl[%0d] i_arready", r), {31'd0, i_arready}, {31'd0, tbl[r].e_iard});
      chk($sformatf("tbl[%0d] arvalid", r), {31'd0, arvalid}, {31'd0, tbl[r].e_arv});
      chk($sformatf("tbl[%0d] araddr", r), araddr, tbl[r].e_addr);
      chk($sformatf("tbl[%0d] rready", r), {31'd0, rready}, {31'd0, tbl[r].e_rr});
      chk($sformatf("tbl[%0d] d_rvalid", r), {31'd0, d_rvalid}, {31'd0, tbl[r].e_drv});
      chk($sformatf("tbl[%0d] i_rvalid", r), {31'd0, i_rvalid}, {31'd0, tbl[r].e_irv});
      if (tbl[r].rv) begin
        chk($sformatf("tbl[%0d] d_rdata", r), d_rdata, tbl[r].rd);
        chk($sformatf("tbl[%0d] i_rdata", r), i_rdata, tbl[r].rd);
      end
      if (tbl[r].e_arv && (tbl[r].e_addr == 32'h1c00_0040)) begin
        chk("t1 arlen", {24'd0, arlen}, 32'd0);
        chk("t1 arid", {28'd0, arid}, 32'd1);
      end
    end

    // Starvation bound: both sides request continuously -> d,d,d,d,i repeating.
    t3_exp = 10'b01111_01111;
    k = 0;
    @(negedge clk);
    idle_inputs();
    d_arvalid = 1'b1; d_araddr = 32'h0000_d000;
    i_arvalid = 1'b1; i_araddr = 32'h0000_1100;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    for (int c = 0; c < 60 && k < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (d_arready || i_arready) begin
        chk($sformatf("t3 one grant %0d", k), {31'd0, d_arready & i_arready}, 32'd0);
        chk($sformatf("t3 grant %0d is d", k), {31'd0, d_arready}, {31'd0, t3_exp[k]});
        k++;
      end
    end
    chk("t3 grant count", k, 10);
    @(negedge clk);
    d_arvalid = 1'b0; i_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();

    // Inst burst of 8 beats with slave gaps and master stalls.
    i_arvalid = 1'b1; i_araddr = 32'h0000_2000; i_arlen = 8'd7; i_arid = 4'd3;
    #1;
    chk("t4 i_arready", {31'd0, i_arready}, 32'd1);
    @(negedge clk);
    i_arvalid = 1'b0; arready = 1'b1;
    #1;
    chk("t4 arvalid", {31'd0, arvalid}, 32'd1);
    chk("t4 arlen", {24'd0, arlen}, 32'd7);
    chk("t4 arid", {28'd0, arid}, 32'd3);
    b = 0;
    for (int c = 0; c < 60 && b < 8; c++) begin
      @(negedge clk);
      arready   = 1'b0;
      rvalid    = ((c % 3) != 1);
      i_rready  = ((c % 4) != 2);
      d_rready  = 1'b1;
      beat_data = 32'h0000_00a0 + 32'(b);
      rdata     = beat_data;
      rlast     = (b == 7);
      #1;
      chk($sformatf("t4 c%0d rready", c), {31'd0, rready}, {31'd0, i_rready});
      chk($sformatf("t4 c%0d i_rvalid", c), {31'd0, i_rvalid}, {31'd0, rvalid});
      chk($sformatf("t4 c%0d d_rvalid", c), {31'd0, d_rvalid}, 32'd0);
      if (rvalid && i_rready) begin
        chk($sformatf("t4 beat%0d data", b), i_rdata, beat_data);
        chk($sformatf("t4 beat%0d last", b), {31'd0, i_rlast}, {31'd0, (b == 7)});
        b++;
      end
    end
    chk("t4 beats", b, 8);

    // AR stall: arready low for 10 cycles, fields stable, no acks to either side.
    @(negedge clk);
    idle_inputs();
    d_arvalid = 1'b1; d_araddr = 32'h3000_0000;
    #1;
    chk("t5 idle after rlast", {31'd0, d_arready}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      d_arvalid = 1'b1; d_araddr = 32'h3000_0004;
      i_arvalid = 1'b1; i_araddr = 32'h0000_3000;
      arready = 1'b0;
      #1;
      chk($sformatf("t5 c%0d arvalid", c), {31'd0, arvalid}, 32'd1);
      chk($sformatf("t5 c%0d araddr", c), araddr, 32'h3000_0000);
      chk($sformatf("t5 c%0d acks", c), {30'd0, d_arready, i_arready}, 32'd0);
    end
    @(negedge clk);
    arready = 1'b1; d_arvalid = 1'b0; i_arvalid = 1'b0;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; d_rready = 1'b1;
    #1;
    chk("t5 d_rvalid", {31'd0, d_rvalid}, 32'd1);

    // Asynchronous reset while in the R state.
    @(negedge clk);
    idle_inputs();
    d_arvalid = 1'b1; d_araddr = 32'h4000_0000;
    #1;
    chk("t6 d_arready", {31'd0, d_arready}, 32'd1);
    @(negedge clk);
    d_arvalid = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; d_rready = 1'b1; i_rready = 1'b1;
    d_arvalid = 1'b1; i_arvalid = 1'b1;
    #1;
    chk("t6 in R d_rvalid", {31'd0, d_rvalid}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("t6 rst rvalids", {30'd0, d_rvalid, i_rvalid}, 32'd0);
    chk("t6 rst rready", {31'd0, rready}, 32'd0);
    chk("t6 rst acks", {30'd0, d_arready, i_arready}, 32'd0);
    chk("t6 rst araddr", araddr, 32'd0);
    @(negedge clk);
    chk("t6 rst arvalid", {31'd0, arvalid}, 32'd0);
    resetn = 1'b1;
    rvalid = 1'b0; i_arvalid = 1'b0;
    d_arvalid = 1'b1; d_araddr = 32'h5000_0000;
    #1;
    chk("t6 post-rst d_arready", {31'd0, d_arready}, 32'd1);
    @(negedge clk);
    d_arvalid = 1'b0; arready = 1'b1;
    #1;
    chk("t6 post-rst arvalid", {31'd0, arvalid}, 32'd1);
    chk("t6 post-rst araddr", araddr, 32'h5000_0000);
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    #1;
    chk("t6 post-rst d_rvalid", {31'd0, d_rvalid}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t6 back idle rready", {31'd0, rready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
